// File: rtl/pll_reset_seq.sv
// Reset sequencer for the on-chip PLL: hold PLL in reset, let it settle, then
// prove it alive with heartbeat edges before releasing the system reset.
// A heartbeat watchdog in RUN, or a soft request, re-runs the whole sequence.
module pll_reset_seq #(
   parameter int PLL_RST_CYCLES = 240,
   parameter int SETTLE_CYCLES  = 2400,
   parameter int HB_WINDOW      = 64,
   parameter int HB_MIN_EDGES   = 4,
   parameter int CNT_W          = 16
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       soft_req,
   input  logic       pll_hb,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [2:0] state_o,
   output logic [7:0] restart_cnt
);

   // Edge counter saturates at HB_MIN_EDGES; one spare code keeps the add safe.
   localparam int EW = $clog2(HB_MIN_EDGES + 2);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(HB_WINDOW - 1);
   localparam logic [EW-1:0]    MIN_EDGES   = EW'(HB_MIN_EDGES);

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
   logic [EW-1:0]    edge_sum;
   logic             hb_s1_q, hb_s1_d;
   logic             hb_s2_q, hb_s2_d;
   logic             hb_s3_q, hb_s3_d;
   logic [7:0]       restart_q, restart_d;
   logic             pll_reset_q, pll_reset_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ready_q, ready_d;
   logic             hb_edge;
   logic             win_end;
   logic             edges_ok;

   // A heartbeat edge arriving on the window-end cycle still counts for that window.
   assign hb_edge  = hb_s2_q ^ hb_s3_q;
   assign win_end  = (cnt_q == WIN_LAST);
   assign edge_sum = (edge_cnt_q == MIN_EDGES) ? edge_cnt_q : edge_cnt_q + EW'(hb_edge);
   assign edges_ok = (edge_sum >= MIN_EDGES);

   // State register.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: timed phases, heartbeat verdict at window ends, soft request wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOLD:   if (cnt_q == HOLD_LAST) state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == SETTLE_LAST) state_d = ST_CHECK;
         ST_CHECK:  if (win_end) state_d = edges_ok ? ST_RUN : ST_FAULT;
         ST_RUN:    if (win_end && !edges_ok) state_d = ST_FAULT;
         ST_FAULT:  state_d = ST_HOLD;
         default:   state_d = ST_FAULT;
      endcase
      if (soft_req) begin
         state_d = ST_HOLD;
      end
   end

   // Outputs are registered from the next state so the PLL reset never glitches.
   // System reset is released one cycle into RUN and dropped on the cycle RUN is left.
   always_comb begin
      pll_reset_d = !(state_d inside {ST_SETTLE, ST_CHECK, ST_RUN});
      sys_rst_n_d = (state_q == ST_RUN) && (state_d == ST_RUN);
      ready_d     = (state_q == ST_RUN) && (state_d == ST_RUN);
   end

   // Datapath next values: synchronizer, cycle counter, edge counter, restart count.
   always_comb begin
      hb_s1_d = pll_hb;
      hb_s2_d = hb_s1_q;
      hb_s3_d = hb_s2_q;

      cnt_d = cnt_q + CNT_W'(1);
      if ((state_d != state_q) || (state_q == ST_RUN && win_end) ||
          (state_q == ST_HOLD && soft_req)) begin
         cnt_d = '0;
      end

      edge_cnt_d = edge_sum;
      if ((state_d != state_q) || (state_q == ST_RUN && win_end)) begin
         edge_cnt_d = '0;
      end

      restart_d = restart_q;
      if (state_d == ST_FAULT && state_q != ST_FAULT && restart_q != 8'hFF) begin
         restart_d = restart_q + 8'd1;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         edge_cnt_q  <= '0;
         hb_s1_q     <= 1'b0;
         hb_s2_q     <= 1'b0;
         hb_s3_q     <= 1'b0;
         restart_q   <= 8'd0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         hb_s1_q     <= hb_s1_d;
         hb_s2_q     <= hb_s2_d;
         hb_s3_q     <= hb_s3_d;
         restart_q   <= restart_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
      end
   end

   assign pll_reset   = pll_reset_q;
   assign sys_rst_n   = sys_rst_n_q;
   assign ready       = ready_q;
   assign state_o     = state_q;
   assign restart_cnt = restart_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with short phase lengths. Stimulus predicts the state
// transitions (state, cycle window, restart count) into a queue; a monitor pops
// and compares each time state_o changes and checks per-cycle output rules.
module tb_pll_reset_seq;

   localparam int P = 8;
   localparam int S = 16;
   localparam int W = 16;
   localparam int M = 4;

   logic       refclk;
   logic       rst_n;
   logic       soft_req;
   logic       pll_hb;
   logic       pll_reset;
   logic       sys_rst_n;
   logic       ready;
   logic [2:0] state_o;
   logic [7:0] restart_cnt;

   pll_reset_seq #(
      .PLL_RST_CYCLES(P),
      .SETTLE_CYCLES (S),
      .HB_WINDOW     (W),
      .HB_MIN_EDGES  (M),
      .CNT_W         (16)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .soft_req   (soft_req),
      .pll_hb     (pll_hb),
      .pll_reset  (pll_reset),
      .sys_rst_n  (sys_rst_n),
      .ready      (ready),
      .state_o    (state_o),
      .restart_cnt(restart_cnt)
   );

   typedef struct {
      logic [2:0] st;
      bit         rel;   // lo/hi are offsets from the previous transition
      int         lo;
      int         hi;
      int         rc;
   } ev_t;

   ev_t        sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_ev = 0;
   int         exp_rc = 0;
   logic [2:0] prev_st = 3'd0;
   bit         hb_run = 1'b1;
   int         hb_per = 3;
   int         hb_ph = 0;

   initial begin
      refclk = 1'b0;
      forever #21 refclk = ~refclk;
   end

   always @(posedge refclk) cyc <= cyc + 1;

   // Heartbeat source: toggles every hb_per refclk cycles, off-grid from refclk.
   initial begin
      pll_hb = 1'b0;
      forever begin
         @(negedge refclk);
         #7;
         if (hb_run) begin
            hb_ph++;
            if (hb_ph >= hb_per) begin
               hb_ph  = 0;
               pll_hb = ~pll_hb;
            end
         end
      end
   end

   // Monitor: compare each state change against the queue, and output levels every cycle.
   always @(negedge refclk) begin
      ev_t  e;
      int   lo;
      int   hi;
      logic exp_on;
      logic exp_pll;
      if (state_o !== prev_st) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_transition: state %0d -> %0d at cycle %0d, no transition required",
                     prev_st, state_o, cyc);
         end else begin
            e  = sb.pop_front();
            lo = e.rel ? last_ev + e.lo : e.lo;
            hi = e.rel ? last_ev + e.hi : e.hi;
            if (state_o !== e.st || cyc < lo || cyc > hi || restart_cnt !== 8'(e.rc)) begin
               errors++;
               $display("FAIL transition: got state %0d at cycle %0d restart_cnt %0d, required state %0d at cycle %0d..%0d restart_cnt %0d",
                        state_o, cyc, restart_cnt, e.st, lo, hi, e.rc);
            end
         end
         last_ev = cyc;
      end
      exp_on  = (state_o == 3'd3) && (prev_st == 3'd3);
      exp_pll = (state_o == 3'd0) || (state_o == 3'd4);
      checks++;
      if (pll_reset !== exp_pll || sys_rst_n !== exp_on || ready !== exp_on) begin
         errors++;
         $display("FAIL outputs_vs_state: cycle %0d state %0d got pll_reset %b sys_rst_n %b ready %b, required %b %b %b",
                  cyc, state_o, pll_reset, sys_rst_n, ready, exp_pll, exp_on, exp_on);
      end
      prev_st = state_o;
   end

   task automatic push_ev(input logic [2:0] st, input bit rel, input int lo, input int hi);
      ev_t e;
      if (st == 3'd4 && exp_rc < 255) exp_rc++;
      e.st  = st;
      e.rel = rel;
      e.lo  = lo;
      e.hi  = hi;
      e.rc  = exp_rc;
      sb.push_back(e);
   endtask

   // Full sequence after entering HOLD; extra = cycles HOLD is stretched by soft_req.
   task automatic push_rerun(input int extra);
      push_ev(3'd1, 1'b1, P + extra, P + extra);
      push_ev(3'd2, 1'b1, S, S);
      push_ev(3'd3, 1'b1, W, W);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge refclk);
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge refclk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d required transitions still pending after %0d cycles, required 0",
                  name, sb.size(), budget);
         sb.delete();
      end
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   initial begin
      int r;
      int c;
      int tc;
      int len;

      rst_n    = 1'b1;
      soft_req = 1'b0;
      hb_per   = $urandom_range(1, 3);
      #1 rst_n = 1'b0;
      wait_cyc(3);
      chk("reset_pll_reset", {7'd0, pll_reset}, 8'd1);
      chk("reset_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
      chk("reset_ready", {7'd0, ready}, 8'd0);
      chk("reset_state", {5'd0, state_o}, 8'd0);
      chk("reset_restart_cnt", restart_cnt, 8'd0);

      // Healthy bring-up: SETTLE at +8, CHECK at +24, RUN at +40, sys_rst_n at +41.
      r = cyc;
      push_ev(3'd1, 1'b0, r + P, r + P);
      push_ev(3'd2, 1'b0, r + P + S, r + P + S);
      push_ev(3'd3, 1'b0, r + P + S + W, r + P + S + W);
      #5 rst_n = 1'b1;
      wait_until(r + P + S + W);
      chk("bringup_state_at_40", {5'd0, state_o}, 8'd3);
      chk("bringup_sys_rst_n_at_40", {7'd0, sys_rst_n}, 8'd0);
      wait_cyc(1);
      chk("bringup_sys_rst_n_at_41", {7'd0, sys_rst_n}, 8'd1);
      chk("bringup_ready_at_41", {7'd0, ready}, 8'd1);
      wait_drain(10, "bringup");
      wait_cyc(W * $urandom_range(1, 5));

      // Heartbeat loss in RUN: fault within two windows, then recover once it resumes.
      c = cyc;
      hb_run = 1'b0;
      push_ev(3'd4, 1'b0, c + 1, c + 2 * W);
      push_ev(3'd0, 1'b1, 1, 1);
      push_rerun(0);
      for (int i = 0; i < 3 * W && state_o !== 3'd4; i++) @(negedge refclk);
      hb_per = $urandom_range(1, 3);
      hb_run = 1'b1;
      wait_drain(150, "hb_loss_recovery");

      // Soft requests of 1, 5 and random length in RUN.
      for (int k = 0; k < 3; k++) begin
         len = (k == 0) ? 1 : (k == 1) ? 5 : $urandom_range(2, 6);
         wait_cyc($urandom_range(3, 40));
         c = cyc;
         push_ev(3'd0, 1'b0, c + 1, c + 1);
         push_rerun(len - 1);
         soft_req = 1'b1;
         wait_cyc(len);
         soft_req = 1'b0;
         wait_drain(150, "soft_req_rerun");
      end

      // Soft request on the same cycle as a failing CHECK window end: HOLD, no count.
      c = cyc;
      hb_run = 1'b0;
      push_ev(3'd0, 1'b0, c + 1, c + 1);
      push_ev(3'd1, 1'b1, P, P);
      push_ev(3'd2, 1'b1, S, S);
      push_ev(3'd0, 1'b1, W, W);
      push_rerun(0);
      soft_req = 1'b1;
      wait_cyc(1);
      soft_req = 1'b0;
      tc = c + 1 + P + S;
      wait_until(tc + W - 1);
      soft_req = 1'b1;
      wait_cyc(1);
      soft_req = 1'b0;
      hb_run = 1'b1;
      wait_drain(150, "soft_vs_window_fault");

      // Asynchronous reset mid-RUN: reset values before the next refclk edge.
      wait_cyc($urandom_range(2, 30));
      c = cyc;
      exp_rc = 0;
      push_ev(3'd0, 1'b0, c + 1, c + 1);
      #5 rst_n = 1'b0;
      #1;
      chk("async_pll_reset", {7'd0, pll_reset}, 8'd1);
      chk("async_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
      chk("async_ready", {7'd0, ready}, 8'd0);
      chk("async_state", {5'd0, state_o}, 8'd0);
      chk("async_restart_cnt", restart_cnt, 8'd0);

      // Dead heartbeat from reset: 300 CHECK faults, restart_cnt saturates at 255.
      hb_run = 1'b0;
      wait_cyc(2);
      r = cyc;
      push_ev(3'd1, 1'b0, r + P, r + P);
      push_ev(3'd2, 1'b1, S, S);
      push_ev(3'd4, 1'b1, W, W);
      push_ev(3'd0, 1'b1, 1, 1);
      for (int i = 1; i < 300; i++) begin
         push_ev(3'd1, 1'b1, P, P);
         push_ev(3'd2, 1'b1, S, S);
         push_ev(3'd4, 1'b1, W, W);
         push_ev(3'd0, 1'b1, 1, 1);
      end
      #5 rst_n = 1'b1;
      wait_drain(300 * (P + S + W + 1) + 50, "watchdog_saturation");
      chk("restart_saturated", restart_cnt, 8'd255);
      chk("sys_rst_n_low_while_faulting", {7'd0, sys_rst_n}, 8'd0);
      hb_run = 1'b1;
      push_rerun(0);
      wait_drain(150, "recover_after_saturation");
      wait_cyc(2);
      chk("final_ready", {7'd0, ready}, 8'd1);
      chk("final_restart_cnt", restart_cnt, 8'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
